multicycle_datapath: RTL and testbench

16-bit multicycle RISC datapath: PC, instruction register, 8x16 register file, add/sub ALU with NZC status, unified 256x16 instruction/data memory and the inter-stage latches. Sits under the external controller, which decodes `opcode`/`ALUopcode`/`PSW_NZC` and drives every select and enable each cycle. A bench-side memory port preloads programs.

---
 rtl/multicycle_datapath_pkg.sv | 38 +++
 rtl/multicycle_datapath_alu16.sv | 28 ++
 rtl/multicycle_datapath.sv | 160 ++++++++++++++++
 tb/tb_multicycle_datapath.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_datapath_pkg.sv
// Shared definitions for the multicycle datapath: instruction field positions,
// next-PC modes, ALU operation encodings and sign-extension helpers.
package multicycle_datapath_pkg;

    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 11;
    localparam int RD_HI    = 10;
    localparam int RD_LO    = 8;
    localparam int RM_HI    = 7;
    localparam int RM_LO    = 5;
    localparam int RN_HI    = 4;
    localparam int RN_LO    = 2;
    localparam int IMM8_HI  = 7;
    localparam int IMM5_HI  = 4;
    localparam int SUBOP_HI = 1;
    localparam int OFF11_HI = 10;

    typedef enum logic [1:0] {
        JMP_SEQ     = 2'b00,
        JMP_REL     = 2'b01,
        JMP_REG     = 2'b10,
        JMP_SEQ_ALT = 2'b11
    } jump_e;

    typedef enum logic {
        ALUOP_ADD = 1'b0,
        ALUOP_SUB = 1'b1
    } aluop_e;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [15:0] sext11(input logic [10:0] v);
        return {{5{v[10]}}, v};
    endfunction

endpackage

// File: rtl/multicycle_datapath_alu16.sv
// 16-bit add/subtract unit with external carry-in and N/Z/C status.
module alu16
    import multicycle_datapath_pkg::*;
(
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        sub,
    input  logic        cin,
    output logic [15:0] r,
    output logic        n,
    output logic        z,
    output logic        c
);

    logic [15:0] y_eff;
    logic [16:0] sum;

    // Subtraction is X + ~Y + cin, so C is the "no borrow" flag.
    always_comb begin
        y_eff = (aluop_e'(sub) == ALUOP_SUB) ? ~y : y;
        sum   = {1'b0, x} + {1'b0, y_eff} + {16'b0, cin};
        r     = sum[15:0];
        c     = sum[16];
        n     = sum[15];
        z     = (sum[15:0] == 16'h0000);
    end

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle 16-bit datapath driven by an external controller.
// Define DATAPATH_DEBUG_OUT_EN to drive OutM/OutPC/OutNextPC; otherwise they read 0.
module multicycle_datapath
    import multicycle_datapath_pkg::*;
(
    input  logic        clk,
    input  logic        Rst,
    input  logic        Buff_PC,
    input  logic        Buff_MEMIns,
    input  logic        Buff_PSW,
    input  logic        WE_RF,
    input  logic        WE_MEM,
    input  logic        MEMresource,
    input  logic        RBresource,
    input  logic        oprandB,
    input  logic        ALUop,
    input  logic        Flag,
    input  logic        LI,
    input  logic        LIorMOV,
    input  logic        ALUorNot,
    input  logic        WBresource,
    input  logic        PCplus1orWB,
    input  logic        Branch,
    input  logic [1:0]  Jump,
    input  logic        TBorNot,
    input  logic        Tb_MEMWE,
    input  logic [7:0]  Tb_MEMAddr,
    input  logic [15:0] Tb_MEMData,
    output logic [15:0] OutR,
    output logic [2:0]  PSW_NZC,
    output logic [4:0]  opcode,
    output logic [1:0]  ALUopcode,
    output logic [15:0] OutM,
    output logic [15:0] OutPC,
    output logic [15:0] OutNextPC
);

    logic [15:0] pc_q, pc_d, ir_q, ir_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [15:0] alu_out_q, alu_out_d, mdr_q, mdr_d, wb_q, wb_d;
    logic [2:0]  psw_q, psw_d;
    logic [15:0] rf_q [8];
    logic [15:0] rf_d [8];
    logic [15:0] mem_q [256];

    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_we;
    logic [15:0] alu_y, alu_r;
    logic        alu_cin, alu_n, alu_z, alu_c;
    logic [15:0] li_val, sel_val, rf_wdata, next_pc;
    logic [2:0]  rb_addr;

    // The bench port owns the memory completely while TBorNot is high.
    always_comb begin
        mem_addr  = TBorNot ? Tb_MEMAddr : (MEMresource ? alu_out_q[7:0] : pc_q[7:0]);
        mem_wdata = TBorNot ? Tb_MEMData : b_q;
        mem_we    = TBorNot ? Tb_MEMWE   : WE_MEM;
    end

    assign mem_rdata = mem_q[mem_addr];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    always_comb begin
        alu_y   = oprandB ? {11'b0, ir_q[IMM5_HI:0]} : b_q;
        alu_cin = Flag ? psw_q[0] : (aluop_e'(ALUop) == ALUOP_SUB);
    end

    alu16 u_alu (
        .x   (a_q),
        .y   (alu_y),
        .sub (ALUop),
        .cin (alu_cin),
        .r   (alu_r),
        .n   (alu_n),
        .z   (alu_z),
        .c   (alu_c)
    );

    // PC still holds the current instruction's address, so offsets add to pc_q.
    always_comb begin
        if (Branch) begin
            next_pc = pc_q + sext8(ir_q[IMM8_HI:0]);
        end else begin
            case (jump_e'(Jump))
                JMP_REL: next_pc = pc_q + sext11(ir_q[OFF11_HI:0]);
                JMP_REG: next_pc = a_q;
                default: next_pc = pc_q + 16'd1;
            endcase
        end
    end

    always_comb begin
        rb_addr   = RBresource ? ir_q[RD_HI:RD_LO] : ir_q[RN_HI:RN_LO];
        li_val    = LI ? {ir_q[IMM8_HI:0], b_q[7:0]} : {8'h00, ir_q[IMM8_HI:0]};
        sel_val   = LIorMOV ? a_q : li_val;
        rf_wdata  = PCplus1orWB ? (WBresource ? mdr_q : wb_q) : (pc_q + 16'd1);

        pc_d      = Buff_PC ? next_pc : pc_q;
        ir_d      = Buff_MEMIns ? mem_rdata : ir_q;
        psw_d     = Buff_PSW ? {alu_n, alu_z, alu_c} : psw_q;
        a_d       = rf_q[ir_q[RM_HI:RM_LO]];
        b_d       = rf_q[rb_addr];
        alu_out_d = alu_r;
        mdr_d     = mem_rdata;
        wb_d      = ALUorNot ? sel_val : alu_out_q;

        rf_d = rf_q;
        if (WE_RF) begin
            rf_d[ir_q[RD_HI:RD_LO]] = rf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!Rst) begin
            pc_q      <= '0;
            ir_q      <= '0;
            psw_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            wb_q      <= '0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            psw_q     <= psw_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
            wb_q      <= wb_d;
            rf_q      <= rf_d;
        end
    end

    assign OutR      = rf_q[ir_q[RM_HI:RM_LO]];
    assign PSW_NZC   = psw_q;
    assign opcode    = ir_q[OPC_HI:OPC_LO];
    assign ALUopcode = ir_q[SUBOP_HI:0];

`ifdef DATAPATH_DEBUG_OUT_EN
    assign OutM      = mem_rdata;
    assign OutPC     = pc_q;
    assign OutNextPC = next_pc;
`else
    assign OutM      = 16'h0000;
    assign OutPC     = 16'h0000;
    assign OutNextPC = 16'h0000;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: acts as the controller, preloads
// programs through the bench memory port and checks a table of trace records.
module tb_multicycle_datapath;

   logic        clk = 1'b0;
   logic        Rst;
   logic        Buff_PC, Buff_MEMIns, Buff_PSW, WE_RF, WE_MEM;
   logic        MEMresource, RBresource, oprandB, ALUop, Flag;
   logic        LI, LIorMOV, ALUorNot, WBresource, PCplus1orWB, Branch;
   logic [1:0]  Jump;
   logic        TBorNot, Tb_MEMWE;
   logic [7:0]  Tb_MEMAddr;
   logic [15:0] Tb_MEMData;
   logic [15:0] OutR, OutM, OutPC, OutNextPC;
   logic [2:0]  PSW_NZC;
   logic [4:0]  opcode;
   logic [1:0]  ALUopcode;

   always #5 clk = ~clk;

   multicycle_datapath dut (
      .clk         (clk),
      .Rst         (Rst),
      .Buff_PC     (Buff_PC),
      .Buff_MEMIns (Buff_MEMIns),
      .Buff_PSW    (Buff_PSW),
      .WE_RF       (WE_RF),
      .WE_MEM      (WE_MEM),
      .MEMresource (MEMresource),
      .RBresource  (RBresource),
      .oprandB     (oprandB),
      .ALUop       (ALUop),
      .Flag        (Flag),
      .LI          (LI),
      .LIorMOV     (LIorMOV),
      .ALUorNot    (ALUorNot),
      .WBresource  (WBresource),
      .PCplus1orWB (PCplus1orWB),
      .Branch      (Branch),
      .Jump        (Jump),
      .TBorNot     (TBorNot),
      .Tb_MEMWE    (Tb_MEMWE),
      .Tb_MEMAddr  (Tb_MEMAddr),
      .Tb_MEMData  (Tb_MEMData),
      .OutR        (OutR),
      .PSW_NZC     (PSW_NZC),
      .opcode      (opcode),
      .ALUopcode   (ALUopcode),
      .OutM        (OutM),
      .OutPC       (OutPC),
      .OutNextPC   (OutNextPC)
   );

   typedef enum {K_LLI, K_LHI, K_ADD, K_SBB, K_NOP, K_BEQ, K_BNE, K_BAL,
                 K_STR, K_LDR, K_MOV, K_JR, K_HLT} kind_e;

   typedef struct packed {
      logic       buffPc;
      logic       buffIr;
      logic       buffPsw;
      logic       weRf;
      logic       weMem;
      logic       memRes;
      logic       rbRes;
      logic       opB;
      logic       aluOp;
      logic       flag;
      logic       li;
      logic       liOrMov;
      logic       aluOrNot;
      logic       wbRes;
      logic       pcp1OrWb;
      logic       branch;
      logic [1:0] jump;
   } ctrl_t;

   typedef struct {
      logic [15:0] expPc;
      logic [15:0] expR1;
      logic [2:0]  expNzc;
      bit          chkOutR;
      logic [15:0] expOutR;
   } vec_t;

   int checks = 0;
   int failures = 0;

   kind_e       progKind [16];
   logic [15:0] progWord [16];
   vec_t        vecs [12];

   // Drive one cycle's worth of control, then sample 1 time unit after the edge.
   task automatic applyStimulus(input ctrl_t c);
      Buff_PC     = c.buffPc;
      Buff_MEMIns = c.buffIr;
      Buff_PSW    = c.buffPsw;
      WE_RF       = c.weRf;
      WE_MEM      = c.weMem;
      MEMresource = c.memRes;
      RBresource  = c.rbRes;
      oprandB     = c.opB;
      ALUop       = c.aluOp;
      Flag        = c.flag;
      LI          = c.li;
      LIorMOV     = c.liOrMov;
      ALUorNot    = c.aluOrNot;
      WBresource  = c.wbRes;
      PCplus1orWB = c.pcp1OrWb;
      Branch      = c.branch;
      Jump        = c.jump;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic loadWord(input logic [7:0] addr, input logic [15:0] data);
      TBorNot    = 1'b1;
      Tb_MEMWE   = 1'b1;
      Tb_MEMAddr = addr;
      Tb_MEMData = data;
      applyStimulus('0);
      TBorNot    = 1'b0;
      Tb_MEMWE   = 1'b0;
   endtask

   // Controller model: fetch, then the per-class cycle sequence.
   task automatic execInstr(input kind_e k);
      ctrl_t c;
      if (k == K_HLT) return;
      c = '0;
      c.buffIr = 1'b1;
      applyStimulus(c);
      case (k)
         K_NOP: begin
            c = '0; c.buffPc = 1'b1;
            applyStimulus(c);
         end
         K_BEQ, K_BNE, K_BAL: begin
            c = '0; c.buffPc = 1'b1;
            c.branch = (k == K_BAL) || (k == K_BEQ && PSW_NZC[1]) ||
                       (k == K_BNE && !PSW_NZC[1]);
            applyStimulus(c);
         end
         K_JR: begin
            c = '0;
            applyStimulus(c);
            c.buffPc = 1'b1; c.jump = 2'b10;
            applyStimulus(c);
         end
         K_STR: begin
            c = '0; c.rbRes = 1'b1;
            applyStimulus(c);
            c.opB = 1'b1;
            applyStimulus(c);
            c = '0; c.rbRes = 1'b1; c.memRes = 1'b1; c.weMem = 1'b1; c.buffPc = 1'b1;
            applyStimulus(c);
         end
         default: begin
            c = '0;
            c.rbRes = (k == K_LHI);
            applyStimulus(c);
            if (k == K_ADD || k == K_SBB) begin
               c.buffPsw = 1'b1;
               c.aluOp   = (k == K_SBB);
               c.flag    = (k == K_SBB);
            end
            if (k == K_LDR) c.opB = 1'b1;
            applyStimulus(c);
            c = '0;
            c.rbRes    = (k == K_LHI);
            c.aluOrNot = (k == K_LLI) || (k == K_LHI) || (k == K_MOV);
            c.li       = (k == K_LHI);
            c.liOrMov  = (k == K_MOV);
            c.memRes   = (k == K_LDR);
            applyStimulus(c);
            c = '0;
            c.weRf = 1'b1; c.pcp1OrWb = 1'b1; c.buffPc = 1'b1;
            c.wbRes = (k == K_LDR);
            applyStimulus(c);
         end
      endcase
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      ctrl_t c;
      logic [15:0] w;

      progKind[0] = K_LLI; progWord[0] = 16'h41FA;
      progKind[1] = K_LHI; progWord[1] = 16'h49FF;
      progKind[2] = K_LLI; progWord[2] = 16'h4203;
      progKind[3] = K_ADD; progWord[3] = 16'h0128;
      progKind[4] = K_NOP; progWord[4] = 16'h0820;
      progKind[5] = K_BEQ; progWord[5] = 16'hC003;
      progKind[6] = K_BNE; progWord[6] = 16'hC8FD;
      progKind[7] = K_HLT; progWord[7] = 16'hF800;
      progKind[8] = K_BAL; progWord[8] = 16'hD0FF;

      vecs[0]  = '{16'h0000, 16'h00FA, 3'b000, 1'b0, 16'h0000};
      vecs[1]  = '{16'h0001, 16'hFFFA, 3'b000, 1'b0, 16'h0000};
      vecs[2]  = '{16'h0002, 16'hFFFA, 3'b000, 1'b0, 16'h0000};
      vecs[3]  = '{16'h0003, 16'hFFFD, 3'b100, 1'b0, 16'h0000};
      vecs[4]  = '{16'h0004, 16'hFFFD, 3'b100, 1'b1, 16'hFFFD};
      vecs[5]  = '{16'h0005, 16'hFFFD, 3'b100, 1'b0, 16'h0000};
      vecs[6]  = '{16'h0006, 16'hFFFD, 3'b100, 1'b0, 16'h0000};
      vecs[7]  = '{16'h0003, 16'h0000, 3'b011, 1'b0, 16'h0000};
      vecs[8]  = '{16'h0004, 16'h0000, 3'b011, 1'b1, 16'h0000};
      vecs[9]  = '{16'h0005, 16'h0000, 3'b011, 1'b0, 16'h0000};
      vecs[10] = '{16'h0008, 16'h0000, 3'b011, 1'b0, 16'h0000};
      vecs[11] = '{16'h0007, 16'h0000, 3'b011, 1'b0, 16'h0000};

      Rst = 1'b0; TBorNot = 1'b0; Tb_MEMWE = 1'b0;
      Tb_MEMAddr = '0; Tb_MEMData = '0;
      repeat (3) applyStimulus('0);
      checkOutput("reset_pc", dut.pc_q, 16'h0000);
      checkOutput("reset_psw", {13'b0, PSW_NZC}, 16'h0000);
      checkOutput("reset_opcode", {11'b0, opcode}, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("reset_r%0d", i), dut.rf_q[i], 16'h0000);
      end

      Rst = 1'b1;
      for (int i = 0; i < 9; i++) loadWord(8'(i), progWord[i]);

      // Reset must win over every enable, even with real data on the memory bus.
      Rst = 1'b0;
      c = '0;
      c.buffPc = 1'b1; c.buffIr = 1'b1; c.buffPsw = 1'b1; c.weRf = 1'b1;
      repeat (3) applyStimulus(c);
      checkOutput("rstovr_pc", dut.pc_q, 16'h0000);
      checkOutput("rstovr_opcode", {11'b0, opcode}, 16'h0000);
      checkOutput("rstovr_psw", {13'b0, PSW_NZC}, 16'h0000);
      checkOutput("rstovr_r0", dut.rf_q[0], 16'h0000);
      checkOutput("rstovr_mem0", dut.mem_q[0], 16'h41FA);
      Rst = 1'b1;
      applyStimulus('0);

      for (int v = 0; v < 12; v++) begin
         checkOutput($sformatf("trace%0d_pc", v), dut.pc_q, vecs[v].expPc);
`ifdef DATAPATH_DEBUG_OUT_EN
         checkOutput($sformatf("trace%0d_outpc", v), OutPC, vecs[v].expPc);
`else
         checkOutput($sformatf("trace%0d_outpc_tied", v), OutPC, 16'h0000);
`endif
         execInstr(progKind[vecs[v].expPc[3:0]]);
         checkOutput($sformatf("trace%0d_r1", v), dut.rf_q[1], vecs[v].expR1);
         checkOutput($sformatf("trace%0d_nzc", v), {13'b0, PSW_NZC}, {13'b0, vecs[v].expNzc});
         if (vecs[v].chkOutR) begin
            checkOutput($sformatf("trace%0d_outr", v), OutR, vecs[v].expOutR);
         end
         if (progKind[vecs[v].expPc[3:0]] != K_HLT) begin
            w = progWord[vecs[v].expPc[3:0]];
            checkOutput($sformatf("trace%0d_opcode", v), {11'b0, opcode}, {11'b0, w[15:11]});
         end
      end

      Rst = 1'b0;
      applyStimulus('0);
      Rst = 1'b1;
      loadWord(8'h00, 16'h43F0);
      loadWord(8'h01, 16'h447C);
      loadWord(8'h02, 16'h3460);
      loadWord(8'h03, 16'h3D60);
      loadWord(8'h04, 16'h4605);
      loadWord(8'h05, 16'h4703);
      loadWord(8'h06, 16'h0000);
      loadWord(8'h07, 16'h06DF);
      loadWord(8'h08, 16'h50C0);
      loadWord(8'h09, 16'h8060);
      checkOutput("seq_start_pc", dut.pc_q, 16'h0000);

      execInstr(K_LLI);
      execInstr(K_LLI);
      checkOutput("seq_r3", dut.rf_q[3], 16'h00F0);
      checkOutput("seq_r4", dut.rf_q[4], 16'h007C);
      execInstr(K_STR);
      checkOutput("str_mem_f0", dut.mem_q[8'hF0], 16'h007C);
      checkOutput("str_pc", dut.pc_q, 16'h0003);
      execInstr(K_LDR);
      checkOutput("ldr_r5", dut.rf_q[5], 16'h007C);
      checkOutput("ldr_pc", dut.pc_q, 16'h0004);

      execInstr(K_LLI);
      execInstr(K_LLI);
      execInstr(K_ADD);
      checkOutput("clr_c_nzc", {13'b0, PSW_NZC}, 16'h0002);
      execInstr(K_SBB);
      checkOutput("sbb_r6", dut.rf_q[6], 16'h0001);
      checkOutput("sbb_nzc", {13'b0, PSW_NZC}, 16'h0001);
      checkOutput("sbb_subop", {14'b0, ALUopcode}, 16'h0003);
      execInstr(K_MOV);
      checkOutput("mov_r0", dut.rf_q[0], 16'h0001);
      checkOutput("mov_pc", dut.pc_q, 16'h0009);
      execInstr(K_JR);
      checkOutput("jr_pc", dut.pc_q, 16'h00F0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
